serial_compare_sequencer: RTL
=============================

# serial_compare_sequencer

Sequencer that wraps the MSB-first serial comparator FSM. It accepts a pair of parallel WIDTH-bit operands through a valid/ready handshake and shifts them out one bit pair per cycle, MSB first. It drives the comparator's synchronous clear so each word starts from the equal state. On the LSB cycle it captures the comparator's combinational verdict and presents it as a registered, pulsed result. It sits directly upstream of the comparator (feeding a/b) and directly downstream of it (consuming a_less_b / a_eq_b / a_greater_b).

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- One clock clk; reset rst is asynchronous and active-low.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand pair on in_a/in_b is valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- ser_a  out  1  current bit of A; connects to comparator a.
- ser_b  out  1  current bit of B; connects to comparator b.
- ser_valid  out  1  ser_a/ser_b carry a live bit this cycle.
- ser_first  out  1  current bit is the MSB.
- ser_last  out  1  current bit is the LSB.
- cmp_rst  out  1  active-high synchronous clear for the comparator.
- cmp_lt, cmp_eq, cmp_gt  in  1 each  comparator outputs, combinational from the current bit.
- res_valid  out  1  one-cycle pulse: res_* updated.
- res_lt, res_eq, res_gt  out  1 each  captured verdict; holds until the next capture.

## Operation
- State machine has two states: IDLE and SHIFT. It also holds shift registers sh_a and sh_b (WIDTH bits each) and a bit counter cnt (clog2(WIDTH) bits).
- in_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1). This is combinational from registered state, with no dependency on in_valid.
- Accept = in_valid & in_ready. On accept: sh_a<=in_a, sh_b<=in_b, cnt<=0, state<=SHIFT.
- In SHIFT, when not on the last bit: sh_a/sh_b shift left by 1 (zero fill), cnt<=cnt+1.
- In SHIFT, on the last bit (cnt==WIDTH-1): with accept, reload (back-to-back); otherwise go to IDLE.
- ser_a = sh_a[WIDTH-1] and ser_b = sh_b[WIDTH-1] in SHIFT; both are 0 in IDLE.
- ser_valid = (state==SHIFT).
- ser_first = SHIFT & cnt==0.
- ser_last = SHIFT & cnt==WIDTH-1.
- cmp_rst = (state==IDLE) | ser_last. The comparator therefore enters every word's MSB cycle in its equal state.
- Capture: in the ser_last cycle, at the next edge: res_lt<=cmp_lt, res_eq<=cmp_eq, res_gt<=cmp_gt, res_valid<=1. In all other cycles res_valid<=0 and res_* hold.
- in_a and in_b are sampled only on accept. Changes at other times are ignored.
- No backpressure exists on the serial or result side; the consumer must take res_* on the res_valid pulse.

## Timing
- Reset (rst low, asynchronous): state=IDLE, sh_a=sh_b=0, cnt=0, res_valid=0, res_lt=res_eq=res_gt=0.
- Resulting output values during reset: in_ready=1, ser_*=0, cmp_rst=1.
- Reset release: first accept is possible in the first cycle with rst high.
- Latency:
  - Operand accepted at edge E.
  - MSB is on ser_a/ser_b in cycle E+1; LSB in cycle E+WIDTH.
  - res_valid is high in cycle E+WIDTH+1.
- Throughput: one word per WIDTH cycles. A back-to-back accept in the ser_last cycle puts the next word's ser_first in the immediately following cycle, with no bubble.
- Simultaneous events:
  - Accept and capture in the same ser_last cycle both take effect. res_valid for word N coincides with ser_first of word N+1.
  - cmp_rst=1 in that same cycle resets the comparator for word N+1.
- Reset mid-word: the partial word is discarded, no res_valid is produced, and the previous res_* are cleared to 0.
- in_valid low in the ser_last cycle: state goes to IDLE next cycle; ser_valid=0 and cmp_rst=1 while idle.

## Test plan
Bench uses WIDTH=8 with the MSB-first comparator instantiated between ser_*/cmp_rst and cmp_*.
- Directed values:
  - a=0xA5, b=0xA4: ser_first at E+1, ser_last at E+8, res_valid at E+9 with res_gt=1, res_lt=0, res_eq=0.
  - a=0x3C, b=0x3C: res_eq=1, others 0.
  - a=0x00, b=0xFF: res_lt=1; ser_a bit stream is 0,0,0,0,0,0,0,0 and ser_b is 1×8.
- Back-to-back: 0x80 vs 0x7F, then 0x01 vs 0x02, with in_valid held high.
  - in_ready high only at E and E+8.
  - Second ser_first at E+9, the same cycle as the first res_valid (res_gt=1).
  - Second res_valid at E+17 with res_lt=1.
- Reset mid-word: drop rst at bit 4 of 0xF0 vs 0x0F.
  - All outputs take reset values immediately (asynchronously) and no res_valid is produced.
  - After release, 0x11 vs 0x11 gives res_eq=1 at the expected cycle.
- Idle and hold:
  - in_valid low for 20 cycles after a result: ser_valid=0, cmp_rst=1, in_ready=1, res_* held, res_valid=0.
  - Changing in_a/in_b mid-shift does not alter the serial stream.

Source files
------------

// File: rtl/serial_compare_sequencer.sv
// -----------------------------------------------------------------------------
// serial_compare_sequencer
//
// Purpose:
//   Takes a parallel operand pair through a valid/ready handshake and sends it
//   to an MSB-first serial comparator, one bit pair per cycle. The comparator's
//   synchronous clear is driven so that every word starts from the equal state.
//   The comparator's combinational verdict is captured on the LSB cycle and
//   presented as a registered result with a one-cycle valid pulse.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-low
//   in_valid   : operand pair on in_a/in_b is valid
//   in_ready   : block accepts an operand pair this cycle
//   in_a, in_b : WIDTH-bit operands, sampled only on accept
//   ser_a/b    : current bit of A/B (MSB first), 0 while idle
//   ser_valid  : a live bit pair is on ser_a/ser_b
//   ser_first  : current bit is the MSB
//   ser_last   : current bit is the LSB
//   cmp_rst    : active-high synchronous clear for the comparator
//   cmp_lt/eq/gt : comparator verdict for the current bit (combinational)
//   res_valid  : one-cycle pulse when res_* are updated
//   res_lt/eq/gt : captured verdict, held until the next capture
// -----------------------------------------------------------------------------
module serial_compare_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             cmp_rst,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic             res_valid,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_gt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [WIDTH-1:0] sh_a_r;
    logic [WIDTH-1:0] sh_b_r;
    logic [CW-1:0]    cnt_r;
    logic             last_s;
    logic             accept_s;
    logic             res_valid_r;
    logic             res_lt_r;
    logic             res_eq_r;
    logic             res_gt_r;

    // Handshake and serial-side decode, all from registered state only.
    always_comb begin
        last_s   = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
        in_ready = (state_r == ST_IDLE) || last_s;
        accept_s = in_valid && in_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; on the last bit an accept reloads with no idle bubble.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s && !accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand shift registers and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_a_r <= '0;
            sh_b_r <= '0;
            cnt_r  <= '0;
        end else if (accept_s) begin
            sh_a_r <= in_a;
            sh_b_r <= in_b;
            cnt_r  <= '0;
        end else if ((state_r == ST_SHIFT) && !last_s) begin
            sh_a_r <= {sh_a_r[WIDTH-2:0], 1'b0};
            sh_b_r <= {sh_b_r[WIDTH-2:0], 1'b0};
            cnt_r  <= cnt_r + CW'(1);
        end else begin
            sh_a_r <= sh_a_r;
            sh_b_r <= sh_b_r;
            cnt_r  <= cnt_r;
        end
    end

    // Verdict capture: the comparator output during the LSB cycle is final.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_r <= 1'b0;
            res_lt_r    <= 1'b0;
            res_eq_r    <= 1'b0;
            res_gt_r    <= 1'b0;
        end else if (last_s) begin
            res_valid_r <= 1'b1;
            res_lt_r    <= cmp_lt;
            res_eq_r    <= cmp_eq;
            res_gt_r    <= cmp_gt;
        end else begin
            res_valid_r <= 1'b0;
            res_lt_r    <= res_lt_r;
            res_eq_r    <= res_eq_r;
            res_gt_r    <= res_gt_r;
        end
    end

    // Serial outputs are gated off while idle. The comparator is held clear
    // while idle and cleared again on each LSB so the next MSB starts equal.
    always_comb begin
        ser_valid = (state_r == ST_SHIFT);
        ser_a     = ser_valid && sh_a_r[WIDTH-1];
        ser_b     = ser_valid && sh_b_r[WIDTH-1];
        ser_first = ser_valid && (cnt_r == '0);
        ser_last  = last_s;
        cmp_rst   = (state_r == ST_IDLE) || last_s;
        res_valid = res_valid_r;
        res_lt    = res_lt_r;
        res_eq    = res_eq_r;
        res_gt    = res_gt_r;
    end

endmodule
